cosim_commit_queue: RTL

- Parametrised multi-lane commit buffer that sits between a core's retirement ports and the cosim DPI checker wrapper.
- Each cycle it captures up to COMMITS retirements plus one trap. Valid lanes are packed in program order into a circular buffer.
- Entries drain one per cycle over a valid/ready interface, so the checker can run at a lower rate than the core.
- A failed check halts the drain. Overflow and halt are sticky.

---
 rtl/cosim_commit_queue.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cosim_commit_queue.sv
// cosim_commit_queue
//
// Multi-lane commit buffer between a core's retirement ports and the cosim
// checker. Each cycle up to COMMITS retirements plus one trap are packed, in
// program order, into a circular buffer. The checker drains one entry per
// cycle over a valid/ready interface. A failed check stops the drain until
// reset. Overflow and halt are sticky.
//
// Optional feature: define COSIM_COMMIT_WATCHDOG_EN to add parameter TIMEOUT
// and output port timeout. The timeout flag is sticky and is raised after
// TIMEOUT consecutive cycles with nothing to enqueue.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-low reset
//   commit_*             per-lane retirement info (lane 0 oldest)
//   trap_valid/cause     trap taken this cycle, ordered after all lanes
//   out_*                head entry and valid/ready handshake
//   check_fail           checker verdict, sampled only on a handshake
//   almost_full          fewer than COMMITS+1 free entries (registered)
//   overflow, halted     sticky status flags
//   instret              count of accepted non-trap commits
//   timeout              (watchdog build only) sticky idle timeout

module cosim_commit_queue #(
    parameter int          COMMITS = 2,
    parameter int          DEPTH   = 16,
    parameter int          XLEN    = 64,
    parameter logic [31:0] HARTID  = 32'd0
`ifdef COSIM_COMMIT_WATCHDOG_EN
    ,parameter int         TIMEOUT = 4096
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMITS-1:0]      commit_valid,
    input  logic [COMMITS*XLEN-1:0] commit_pc,
    input  logic [COMMITS*32-1:0]   commit_insn,
    input  logic [COMMITS-1:0]      commit_wen,
    input  logic [COMMITS*5-1:0]    commit_waddr,
    input  logic [COMMITS*XLEN-1:0] commit_wdata,
    input  logic                    trap_valid,
    input  logic [XLEN-1:0]         trap_cause,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_hartid,
    output logic                    out_is_trap,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_insn,
    output logic                    out_wen,
    output logic [4:0]              out_waddr,
    output logic [XLEN-1:0]         out_wdata,
    output logic [XLEN-1:0]         out_cause,
    input  logic                    check_fail,
    output logic                    almost_full,
    output logic                    overflow,
    output logic                    halted,
    output logic [63:0]             instret
`ifdef COSIM_COMMIT_WATCHDOG_EN
    ,output logic                   timeout
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] COMMITS_P1 = CNT_W'(COMMITS + 1);

    // Entry storage; only slots between rptr and wptr are ever observed.
    logic            r_isTrap [DEPTH];
    logic [XLEN-1:0] r_pc     [DEPTH];
    logic [31:0]     r_insn   [DEPTH];
    logic            r_wen    [DEPTH];
    logic [4:0]      r_waddr  [DEPTH];
    logic [XLEN-1:0] r_wdata  [DEPTH];
    logic [XLEN-1:0] r_cause  [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_almostFull;
    logic             r_overflow;
    logic             r_halted;
    logic [63:0]      r_instret;

    logic [PTR_W-1:0] w_laneSlot [COMMITS];
    logic [PTR_W-1:0] w_trapSlot;
    logic [CNT_W-1:0] w_validCount;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_countNext;
    logic             w_accept;
    logic             w_outValid;
    logic             w_handshake;
    logic             w_headLive;
    logic             w_headCommit;

    // Each valid lane lands at wptr plus the number of valid lanes below it,
    // so invalid lanes leave no hole; the trap follows the last valid lane.
    always_comb begin
        w_validCount = '0;
        for (int l = 0; l < COMMITS; l++) begin
            w_laneSlot[l] = r_wptr + PTR_W'(w_validCount);
            w_validCount  = w_validCount + CNT_W'(commit_valid[l]);
        end
        w_trapSlot  = r_wptr + PTR_W'(w_validCount);
        w_n         = w_validCount + CNT_W'(trap_valid);
        // Free space ignores this cycle's pop, so a full buffer rejects even
        // when the checker is draining at the same time.
        w_free      = DEPTH_C - r_count;
        w_accept    = (w_n <= w_free);
        w_outValid  = (r_count != '0) && !r_halted;
        w_handshake = w_outValid && out_ready;
        w_countNext = r_count + (w_accept ? w_n : '0) - CNT_W'(w_handshake);
    end

    // Storage write; a rejected cycle writes nothing at all.
    always_ff @(posedge clock) begin
        if (reset && w_accept) begin
            for (int l = 0; l < COMMITS; l++) begin
                if (commit_valid[l]) begin
                    r_isTrap[w_laneSlot[l]] <= 1'b0;
                    r_pc[w_laneSlot[l]]     <= commit_pc[l*XLEN +: XLEN];
                    r_insn[w_laneSlot[l]]   <= commit_insn[l*32 +: 32];
                    r_wen[w_laneSlot[l]]    <= commit_wen[l];
                    r_waddr[w_laneSlot[l]]  <= commit_waddr[l*5 +: 5];
                    r_wdata[w_laneSlot[l]]  <= commit_wdata[l*XLEN +: XLEN];
                    r_cause[w_laneSlot[l]]  <= '0;
                end
            end
            if (trap_valid) begin
                r_isTrap[w_trapSlot] <= 1'b1;
                r_pc[w_trapSlot]     <= '0;
                r_insn[w_trapSlot]   <= '0;
                r_wen[w_trapSlot]    <= 1'b0;
                r_waddr[w_trapSlot]  <= '0;
                r_wdata[w_trapSlot]  <= '0;
                r_cause[w_trapSlot]  <= trap_cause;
            end
        end
    end

    // Pointers, occupancy and sticky status.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_almostFull <= 1'b0;
            r_overflow   <= 1'b0;
            r_halted     <= 1'b0;
            r_instret    <= '0;
        end else begin
            r_count      <= w_countNext;
            r_almostFull <= (DEPTH_C - w_countNext) < COMMITS_P1;
            if (w_accept) begin
                r_wptr    <= r_wptr + PTR_W'(w_n);
                r_instret <= r_instret + 64'(w_validCount);
            end else begin
                r_overflow <= 1'b1;
            end
            if (w_handshake) begin
                r_rptr <= r_rptr + PTR_W'(1);
                if (check_fail) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

`ifdef COSIM_COMMIT_WATCHDOG_EN
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

    logic [31:0] r_idle;
    logic [31:0] w_idleNext;
    logic        r_timeout;

    always_comb begin
        if (w_n != '0) begin
            w_idleNext = '0;
        end else if (r_idle < TIMEOUT_C) begin
            w_idleNext = r_idle + 32'd1;
        end else begin
            w_idleNext = r_idle;
        end
    end

    // Idle counter saturates at TIMEOUT; the flag stays set until reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_idle <= w_idleNext;
            if (w_idleNext == TIMEOUT_C) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`endif

    // Head fields come straight from storage; commit fields are zeroed for
    // traps and the cause is zeroed for commits, all zero while empty.
    assign w_headLive   = (r_count != '0);
    assign w_headCommit = w_headLive && !r_isTrap[r_rptr];

    assign out_valid   = w_outValid;
    assign out_hartid  = HARTID;
    assign out_is_trap = w_headLive && r_isTrap[r_rptr];
    assign out_pc      = w_headCommit ? r_pc[r_rptr]    : '0;
    assign out_insn    = w_headCommit ? r_insn[r_rptr]  : '0;
    assign out_wen     = w_headCommit ? r_wen[r_rptr]   : 1'b0;
    assign out_waddr   = w_headCommit ? r_waddr[r_rptr] : '0;
    assign out_wdata   = w_headCommit ? r_wdata[r_rptr] : '0;
    assign out_cause   = out_is_trap  ? r_cause[r_rptr] : '0;
    assign almost_full = r_almostFull;
    assign overflow    = r_overflow;
    assign halted      = r_halted;
    assign instret     = r_instret;

endmodule
